ps2_key_event_queue: RTL and testbench

Decodes the raw PS/2 scancode byte stream from the PS/2 interface into key make/break events and buffers them in a small FIFO for the processor. Sits between the PS/2 interface (`ps2_key_data` / `ps2_key_pressed`) and the processor's key-input path, replacing per-byte polling. Also exports live "held" flags for the four arrow keys.

---
 rtl/ps2_pkg.sv | 46 ++++
 rtl/ps2_key_event_queue_if.sv | 25 ++
 rtl/ps2_event_fifo.sv | 66 ++++++
 rtl/ps2_key_event_queue.sv | 152 +++++++++++++++
 tb/tb_ps2_key_event_queue.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 key event queue: scancode values,
// decoder states, the FIFO entry width and the bit positions inside `held`.
package ps2_pkg;

    // Prefix bytes
    localparam logic [7:0] ScE0 = 8'hE0;
    localparam logic [7:0] ScF0 = 8'hF0;

    // Device responses / unsupported bytes that abort any pending prefix
    localparam logic [7:0] ScNul  = 8'h00;
    localparam logic [7:0] ScBat  = 8'hAA;
    localparam logic [7:0] ScE1   = 8'hE1;
    localparam logic [7:0] ScEcho = 8'hEE;
    localparam logic [7:0] ScAck  = 8'hFA;
    localparam logic [7:0] ScFC   = 8'hFC;
    localparam logic [7:0] ScRsnd = 8'hFE;
    localparam logic [7:0] ScErr  = 8'hFF;

    // Extended arrow-key codes
    localparam logic [7:0] ScUp    = 8'h75;
    localparam logic [7:0] ScLeft  = 8'h6B;
    localparam logic [7:0] ScDown  = 8'h72;
    localparam logic [7:0] ScRight = 8'h74;

    // FIFO entry is {ext, brk, code}
    localparam int unsigned EvtW = 10;

    // Bit positions in the `held` vector {up, left, down, right}
    localparam int unsigned HeldUp    = 3;
    localparam int unsigned HeldLeft  = 2;
    localparam int unsigned HeldDown  = 1;
    localparam int unsigned HeldRight = 0;

    typedef enum logic [1:0] {
        StIdle,
        StExt,
        StBrk,
        StExtBrk
    } dec_state_e;

    function automatic logic is_ignored(input logic [7:0] b);
        return (b == ScNul) || (b == ScBat) || (b == ScE1) || (b == ScEcho) ||
               (b == ScAck) || (b == ScFC) || (b == ScRsnd) || (b == ScErr);
    endfunction

endpackage

// File: rtl/ps2_key_event_queue_if.sv
// Event read port of the key queue: show-ahead head entry plus pop strobe.
// master = queue (drives the head), slave = consumer (drives rd_en).
interface ps2_key_event_queue_if;
    logic       rd_en;
    logic       evt_valid;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;

    modport master (
        input  rd_en,
        output evt_valid,
        output evt_code,
        output evt_ext,
        output evt_break
    );

    modport slave (
        output rd_en,
        input  evt_valid,
        input  evt_code,
        input  evt_ext,
        input  evt_break
    );
endinterface

// File: rtl/ps2_event_fifo.sv
// Show-ahead FIFO of DEPTH x EvtW entries with an occupancy count. When full,
// a push is still accepted if a pop happens in the same cycle; otherwise the
// push is dropped and o_drop pulses.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       i_push,
    input  logic [EvtW-1:0]            i_wdata,
    input  logic                       i_pop,
    output logic                       o_valid,
    output logic [EvtW-1:0]            o_rdata,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_drop
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [EvtW-1:0] r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_pop   = i_pop & ~w_empty;
    assign w_push  = i_push & (~w_full | w_pop);
    assign o_drop  = i_push & w_full & ~w_pop;

    // Storage write; contents are only observed through the valid-gated head
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid = ~w_empty;
    assign o_rdata = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/ps2_key_event_queue.sv
// PS/2 scancode decoder feeding a small event FIFO, plus live arrow-key flags.
// Optional build macro: PS2_KEY_TYPEMATIC_FILTER_EN drops repeated identical
// makes (typematic auto-repeat) until a break or reset intervenes.
module ps2_key_event_queue
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [7:0]             ps2_key_data,
    input  logic                   ps2_key_pressed,
    input  logic                   clr_ovf,
    ps2_key_event_queue_if.master  evt_if,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [3:0]             held
);
    dec_state_e r_state;
    logic       r_overflow;
    logic [3:0] r_held;

    logic            w_is_e0;
    logic            w_is_f0;
    logic            w_ign;
    logic            w_emit;
    logic            w_ext;
    logic            w_brk;
    logic            w_repeat;
    logic            w_accept;
    logic            w_drop;
    logic [EvtW-1:0] w_head;

    assign w_is_e0 = (ps2_key_data == ScE0);
    assign w_is_f0 = (ps2_key_data == ScF0);
    assign w_ign   = is_ignored(ps2_key_data);

    // Emit decode: prefixes are only consumed as prefixes before a break marker
    always_comb begin
        w_emit = 1'b0;
        w_ext  = 1'b0;
        w_brk  = 1'b0;
        if (ps2_key_pressed && !w_ign) begin
            unique case (r_state)
                StIdle, StExt: begin
                    w_emit = ~w_is_e0 & ~w_is_f0;
                    w_ext  = (r_state == StExt);
                end
                StBrk: begin
                    w_emit = 1'b1;
                    w_brk  = 1'b1;
                end
                StExtBrk: begin
                    w_emit = 1'b1;
                    w_ext  = 1'b1;
                    w_brk  = 1'b1;
                end
                default: w_emit = 1'b0;
            endcase
        end
    end

    // Decoder FSM, advanced only on byte strobes
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= StIdle;
        end else if (ps2_key_pressed) begin
            if (w_emit || w_ign) begin
                r_state <= StIdle;
            end else begin
                unique case (r_state)
                    StIdle:  r_state <= w_is_e0 ? StExt : StBrk;
                    StExt:   r_state <= w_is_f0 ? StExtBrk : StExt;
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

`ifdef PS2_KEY_TYPEMATIC_FILTER_EN
    logic       r_last_vld;
    logic [8:0] r_last_make;

    // Remember the last make {ext, code}; any break forgets it
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_last_vld  <= 1'b0;
            r_last_make <= '0;
        end else if (w_emit) begin
            if (w_brk) begin
                r_last_vld <= 1'b0;
            end else begin
                r_last_vld  <= 1'b1;
                r_last_make <= {w_ext, ps2_key_data};
            end
        end
    end

    assign w_repeat = w_emit & ~w_brk & r_last_vld & (r_last_make == {w_ext, ps2_key_data});
`else
    assign w_repeat = 1'b0;
`endif

    assign w_accept = w_emit & ~w_repeat;

    // Arrow-key flags track extended make/break regardless of FIFO space
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_held <= '0;
        end else if (w_accept && w_ext) begin
            case (ps2_key_data)
                ScUp:    r_held[HeldUp]    <= ~w_brk;
                ScLeft:  r_held[HeldLeft]  <= ~w_brk;
                ScDown:  r_held[HeldDown]  <= ~w_brk;
                ScRight: r_held[HeldRight] <= ~w_brk;
                default: r_held <= r_held;
            endcase
        end
    end

    // Sticky overflow; a new drop wins over a clear in the same cycle
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    ps2_event_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .resetn  (resetn),
        .i_push  (w_accept),
        .i_wdata ({w_ext, w_brk, ps2_key_data}),
        .i_pop   (evt_if.rd_en),
        .o_valid (evt_if.evt_valid),
        .o_rdata (w_head),
        .o_count (count),
        .o_drop  (w_drop)
    );

    assign evt_if.evt_ext   = w_head[9];
    assign evt_if.evt_break = w_head[8];
    assign evt_if.evt_code  = w_head[7:0];
    assign overflow         = r_overflow;
    assign held             = r_held;

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Scoreboard bench for ps2_key_event_queue: stimulus pushes expected events,
// a negedge monitor pops and compares whenever the queue shows an event.
module tb_ps2_key_event_queue;
    localparam int unsigned DEPTH = 8;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] ps2_key_data = 8'h00;
    logic       ps2_key_pressed = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [3:0] count;
    logic       overflow;
    logic [3:0] held;

    logic rd_mon = 1'b0;
    logic rd_stim = 1'b0;
    logic drain = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [9:0] sb[$];
    logic [9:0] mon_exp;

    ps2_key_event_queue_if evt_if ();
    assign evt_if.rd_en = rd_mon | rd_stim;

    ps2_key_event_queue #(
        .DEPTH (DEPTH)
    ) dut (
        .clock           (clock),
        .resetn          (resetn),
        .ps2_key_data    (ps2_key_data),
        .ps2_key_pressed (ps2_key_pressed),
        .clr_ovf         (clr_ovf),
        .evt_if          (evt_if),
        .count           (count),
        .overflow        (overflow),
        .held            (held)
    );

    always #50 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: compare head to scoreboard and pop it on the next edge
    always @(negedge clock) begin
        if (drain && evt_if.evt_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got %0h want none",
                         {evt_if.evt_ext, evt_if.evt_break, evt_if.evt_code});
            end else begin
                mon_exp = sb.pop_front();
                chk("event", {22'd0, evt_if.evt_ext, evt_if.evt_break, evt_if.evt_code},
                    {22'd0, mon_exp});
            end
            rd_mon = 1'b1;
        end else begin
            rd_mon = 1'b0;
        end
    end

    task automatic send(input logic [7:0] b, input int gap);
        @(posedge clock);
        #1;
        ps2_key_data    = b;
        ps2_key_pressed = 1'b1;
        @(posedge clock);
        #1;
        ps2_key_pressed = 1'b0;
        ps2_key_data    = 8'h00;
        repeat (gap) @(posedge clock);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clock);
            n++;
        end
        chk({name, "_pending"}, sb.size(), 0);
        repeat (2) @(posedge clock);
        #1;
        chk({name, "_valid_after_drain"}, evt_if.evt_valid, 0);
    endtask

    task automatic do_reset();
        #1;
        resetn = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;
    endtask

    logic [7:0] codes9 [9] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
    logic [7:0] codes8 [8] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E};

    initial begin
        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_valid", evt_if.evt_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_held", held, 0);
        chk("rst_head", {evt_if.evt_ext, evt_if.evt_break, evt_if.evt_code}, 0);
        resetn = 1'b1;
        drain  = 1'b1;

        // Plain make then break, with one-cycle latency check
        sb.push_back({2'b00, 8'h1C});
        @(posedge clock);
        #1;
        ps2_key_data    = 8'h1C;
        ps2_key_pressed = 1'b1;
        chk("valid_before_strobe", evt_if.evt_valid, 0);
        @(posedge clock);
        #1;
        ps2_key_pressed = 1'b0;
        chk("valid_latency", evt_if.evt_valid, 1);
        repeat (3) @(posedge clock);
        sb.push_back({2'b01, 8'h1C});
        send(8'hF0, 3);
        send(8'h1C, 3);
        wait_drain("make_break");

        // Extended arrows drive held; non-extended 75 does not
        sb.push_back({2'b10, 8'h75});
        send(8'hE0, 0);
        send(8'h75, 0);
        chk("held_up", held, 4'b1000);
        sb.push_back({2'b11, 8'h75});
        send(8'hE0, 0);
        send(8'hF0, 0);
        send(8'h75, 0);
        chk("held_up_release", held, 4'b0000);
        sb.push_back({2'b10, 8'h6B});
        send(8'hE0, 0);
        send(8'h6B, 0);
        chk("held_left", held, 4'b0100);
        sb.push_back({2'b00, 8'h75});
        send(8'h75, 0);
        chk("held_plain_75", held, 4'b0100);
        sb.push_back({2'b11, 8'h6B});
        send(8'hE0, 0);
        send(8'hF0, 0);
        send(8'h6B, 0);
        chk("held_left_release", held, 4'b0000);
        wait_drain("arrows");

        // Overflow: 9 makes into 8 entries
        drain = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) sb.push_back({2'b00, codes9[i]});
            send(codes9[i], 0);
        end
        #1;
        chk("ovf_count", count, 8);
        chk("ovf_flag", overflow, 1);
        drain = 1'b1;
        wait_drain("ovf_drain");
        chk("ovf_sticky", overflow, 1);
        @(posedge clock);
        #1;
        clr_ovf = 1'b1;
        @(posedge clock);
        #1;
        clr_ovf = 1'b0;
        chk("ovf_cleared", overflow, 0);

        // Full FIFO with pop and push on the same cycle
        drain = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sb.push_back({2'b00, codes8[i]});
            send(codes8[i], 0);
        end
        #1;
        chk("full_count", count, 8);
        mon_exp = sb.pop_front();
        chk("full_head", {22'd0, evt_if.evt_ext, evt_if.evt_break, evt_if.evt_code},
            {22'd0, mon_exp});
        sb.push_back({2'b00, 8'h46});
        @(posedge clock);
        #1;
        ps2_key_data    = 8'h46;
        ps2_key_pressed = 1'b1;
        rd_stim         = 1'b1;
        @(posedge clock);
        #1;
        ps2_key_pressed = 1'b0;
        rd_stim         = 1'b0;
        chk("full_pushpop_count", count, 8);
        chk("full_pushpop_ovf", overflow, 0);
        drain = 1'b1;
        wait_drain("full_pushpop");

        // Ignored byte aborts a pending prefix
        sb.push_back({2'b00, 8'h1C});
        send(8'hE0, 1);
        send(8'hAA, 1);
        send(8'h1C, 1);
        wait_drain("abort");

        // Reset discards queued entries
        drain = 1'b0;
        send(8'h2A, 0);
        do_reset();
        chk("rst_mid_count", count, 0);
        chk("rst_mid_valid", evt_if.evt_valid, 0);
        drain = 1'b1;

        // Reset after lone F0 discards the prefix
        send(8'hF0, 1);
        do_reset();
        sb.push_back({2'b00, 8'h1C});
        send(8'h1C, 1);
        wait_drain("reset_prefix");

        // Typematic repeats
        do_reset();
`ifdef PS2_KEY_TYPEMATIC_FILTER_EN
        sb.push_back({2'b00, 8'h1C});
        sb.push_back({2'b01, 8'h1C});
        sb.push_back({2'b00, 8'h1C});
`else
        sb.push_back({2'b00, 8'h1C});
        sb.push_back({2'b00, 8'h1C});
        sb.push_back({2'b00, 8'h1C});
        sb.push_back({2'b01, 8'h1C});
        sb.push_back({2'b00, 8'h1C});
`endif
        send(8'h1C, 0);
        send(8'h1C, 0);
        send(8'h1C, 0);
        send(8'hF0, 0);
        send(8'h1C, 0);
        send(8'h1C, 0);
        wait_drain("typematic");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
